// File: rtl/palette_ctrl.sv
// Palette RAM sequencer: init sweep, video/CPU read arbitration, CPU byte writes
// and same-cycle write-to-read forwarding in front of a 256x16 dual-port RAM.
module palette_ctrl #(
  parameter int INIT_LEN   = 256,
  parameter bit DEFAULT_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        init_req_i,
  output logic        init_done_o,
  input  logic        vid_req_i,
  input  logic [7:0]  vid_addr_i,
  output logic        vid_valid_o,
  output logic [15:0] vid_data_o,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [7:0]  cpu_addr_i,
  input  logic [1:0]  cpu_ben_i,
  input  logic [15:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [15:0] cpu_rdata_o,
  output logic        ram_wr_en_o,
  output logic [1:0]  ram_ben_o,
  output logic [7:0]  ram_wr_addr_o,
  output logic [15:0] ram_wr_data_o,
  output logic [7:0]  ram_rd_addr_o,
  input  logic [15:0] ram_rd_data_i
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [1:0]  ben_q, ben_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        ack_q, ack_d;
  logic [15:0] rdata_q, rdata_d;
  logic        vid_valid_q, vid_valid_d;
  logic        rd_pend_q, rd_pend_d;
  logic        fwd_hit_q, fwd_hit_d;
  logic [1:0]  fwd_ben_q, fwd_ben_d;
  logic [15:0] fwd_data_q, fwd_data_d;
  logic [15:0] rd_fwd;

  function automatic logic [15:0] default_entry(input logic [3:0] idx);
    case (idx)
      4'd0:  default_entry = 16'h0000;
      4'd1:  default_entry = 16'h0FFF;
      4'd2:  default_entry = 16'h0800;
      4'd3:  default_entry = 16'h0AFE;
      4'd4:  default_entry = 16'h0C4C;
      4'd5:  default_entry = 16'h00C5;
      4'd6:  default_entry = 16'h000A;
      4'd7:  default_entry = 16'h0EE7;
      4'd8:  default_entry = 16'h0D85;
      4'd9:  default_entry = 16'h0640;
      4'd10: default_entry = 16'h0F77;
      4'd11: default_entry = 16'h0333;
      4'd12: default_entry = 16'h0777;
      4'd13: default_entry = 16'h0AF6;
      4'd14: default_entry = 16'h008F;
      default: default_entry = 16'h0BBB;
    endcase
  endfunction

  assign ram_rd_addr_o = vid_req_i ? vid_addr_i : cpu_addr_i;

  // RAM is read-first: bytes written in the read cycle are merged in here.
  always_comb begin
    rd_fwd = ram_rd_data_i;
    if (fwd_hit_q) begin
      if (fwd_ben_q[0]) rd_fwd[7:0]  = fwd_data_q[7:0];
      if (fwd_ben_q[1]) rd_fwd[15:8] = fwd_data_q[15:8];
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    ben_d       = 2'b00;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    rd_pend_d   = 1'b0;
    vid_valid_d = vid_req_i;
    fwd_hit_d   = wr_en_q && (wr_addr_q == ram_rd_addr_o);
    fwd_ben_d   = ben_q;
    fwd_data_d  = wr_data_q;

    case (state_q)
      S_INIT: begin
        wr_en_d   = 1'b1;
        ben_d     = 2'b11;
        wr_addr_d = cnt_q[7:0];
        wr_data_d = (DEFAULT_EN && cnt_q < 9'd16) ? default_entry(cnt_q[3:0]) : 16'h0000;
        if (cnt_q == 9'(INIT_LEN - 1)) begin
          state_d = S_RUN;
          cnt_d   = 9'd0;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end
      default: begin
        if (rd_pend_q) begin
          // Read data returns this cycle; a re-init request waits for the ack.
          ack_d   = 1'b1;
          rdata_d = rd_fwd;
          if (init_req_i) begin
            state_d = S_INIT;
            cnt_d   = 9'd0;
          end
        end else if (init_req_i) begin
          state_d = S_INIT;
          cnt_d   = 9'd0;
        end else if (cpu_req_i) begin
          if (cpu_we_i) begin
            wr_en_d   = |cpu_ben_i;
            ben_d     = cpu_ben_i;
            wr_addr_d = cpu_addr_i;
            wr_data_d = cpu_wdata_i;
            ack_d     = 1'b1;
          end else if (!vid_req_i) begin
            rd_pend_d = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      cnt_q       <= 9'd0;
      wr_en_q     <= 1'b0;
      ben_q       <= 2'b00;
      wr_addr_q   <= 8'h00;
      wr_data_q   <= 16'h0000;
      ack_q       <= 1'b0;
      rdata_q     <= 16'h0000;
      vid_valid_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      fwd_hit_q   <= 1'b0;
      fwd_ben_q   <= 2'b00;
      fwd_data_q  <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_en_q     <= wr_en_d;
      ben_q       <= ben_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      ack_q       <= ack_d;
      rdata_q     <= rdata_d;
      vid_valid_q <= vid_valid_d;
      rd_pend_q   <= rd_pend_d;
      fwd_hit_q   <= fwd_hit_d;
      fwd_ben_q   <= fwd_ben_d;
      fwd_data_q  <= fwd_data_d;
    end
  end

  assign init_done_o   = (state_q == S_RUN);
  assign vid_valid_o   = vid_valid_q;
  assign vid_data_o    = rd_fwd;
  assign cpu_ack_o     = ack_q;
  assign cpu_rdata_o   = rdata_q;
  assign ram_wr_en_o   = wr_en_q;
  assign ram_ben_o     = ben_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;

endmodule

// File: tb/tb_palette_ctrl.sv
// Scoreboard bench for palette_ctrl with a behavioural read-first 256x16 RAM.
module tb_palette_ctrl;
  logic        clk = 1'b0;
  logic        rst_i, init_req_i, init_done_o;
  logic        vid_req_i, vid_valid_o;
  logic [7:0]  vid_addr_i;
  logic [15:0] vid_data_o;
  logic        cpu_req_i, cpu_we_i, cpu_ack_o;
  logic [7:0]  cpu_addr_i;
  logic [1:0]  cpu_ben_i;
  logic [15:0] cpu_wdata_i, cpu_rdata_o;
  logic        ram_wr_en_o;
  logic [1:0]  ram_ben_o;
  logic [7:0]  ram_wr_addr_o, ram_rd_addr_o;
  logic [15:0] ram_wr_data_o, ram_rd_data_i;

  always #5 clk = ~clk;

  palette_ctrl dut (
    .clk_i(clk), .rst_i(rst_i), .init_req_i(init_req_i), .init_done_o(init_done_o),
    .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i), .vid_valid_o(vid_valid_o),
    .vid_data_o(vid_data_o), .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i),
    .cpu_addr_i(cpu_addr_i), .cpu_ben_i(cpu_ben_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ack_o(cpu_ack_o), .cpu_rdata_o(cpu_rdata_o), .ram_wr_en_o(ram_wr_en_o),
    .ram_ben_o(ram_ben_o), .ram_wr_addr_o(ram_wr_addr_o), .ram_wr_data_o(ram_wr_data_o),
    .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i)
  );

  // Read-first RAM: a read in the write cycle returns the old contents.
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (ram_wr_en_o) begin
      if (ram_ben_o[0]) ram[ram_wr_addr_o][7:0]  <= ram_wr_data_o[7:0];
      if (ram_ben_o[1]) ram[ram_wr_addr_o][15:8] <= ram_wr_data_o[15:8];
    end
    ram_rd_data_i <= ram[ram_rd_addr_o];
  end

  localparam logic [15:0] DEF [16] = '{16'h000, 16'hFFF, 16'h800, 16'hAFE, 16'hC4C, 16'h0C5,
                                       16'h00A, 16'hEE7, 16'hD85, 16'h640, 16'hF77, 16'h333,
                                       16'h777, 16'hAF6, 16'h08F, 16'hBBB};

  typedef struct packed {logic [7:0] addr; logic [1:0] ben; logic [15:0] data;} wr_t;

  int tests = 0, fails = 0;
  wr_t         wr_q[$];
  logic [15:0] vid_q[$];
  logic [15:0] cpu_q[$];
  logic [15:0] shadow [256];
  logic [15:0] last_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (!rst_i) begin
      if (ram_wr_en_o) begin
        if (wr_q.size() == 0) check_eq("ram_wr_unexpected", 32'(wr_q.size()), 1);
        else begin
          e = wr_q.pop_front();
          check_eq("ram_wr", {6'b0, ram_wr_addr_o, ram_ben_o, ram_wr_data_o}, {6'b0, e});
        end
      end
      if (vid_valid_o) begin
        if (vid_q.size() == 0) check_eq("vid_unexpected", 32'(vid_q.size()), 1);
        else check_eq("vid_data", {16'h0, vid_data_o}, {16'h0, vid_q.pop_front()});
      end
      if (cpu_ack_o) begin
        if (cpu_q.size() == 0) check_eq("ack_unexpected", 32'(cpu_q.size()), 1);
        else check_eq("cpu_rdata", {16'h0, cpu_rdata_o}, {16'h0, cpu_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_defaults();
    for (int i = 0; i < 256; i++) begin
      shadow[i] = (i < 16) ? DEF[i] : 16'h0;
      wr_q.push_back({8'(i), 2'b11, shadow[i]});
    end
  endtask

  task automatic run_init(input string tag);
    int n = 0;
    int acks = 0;
    while (!init_done_o && n < 400) begin
      tick();
      n++;
      if (cpu_ack_o) acks++;
    end
    check_eq({tag, "_sweep_len"}, n, 256);
    check_eq({tag, "_ack_in_init"}, acks, 0);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack_o && lat < 200);
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    int lat;
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = a; cpu_ben_i = b; cpu_wdata_i = d;
    if (b != 2'b00) wr_q.push_back({a, b, d});
    cpu_q.push_back(last_rd);
    if (b[0]) shadow[a][7:0]  = d[7:0];
    if (b[1]) shadow[a][15:8] = d[15:8];
    wait_ack(lat);
    cpu_req_i = 1'b0;
    check_eq("wr_ack_lat", lat, 1);
  endtask

  task automatic cpu_read(input logic [7:0] a);
    int lat;
    last_rd = shadow[a];
    cpu_q.push_back(last_rd);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = a;
    wait_ack(lat);
    cpu_req_i = 1'b0;
    check_eq("rd_ack_lat", lat, 2);
  endtask

  task automatic vid_lookup(input logic [7:0] a);
    vid_req_i = 1'b1; vid_addr_i = a;
    vid_q.push_back(shadow[a]);
    tick();
    vid_req_i = 1'b0;
  endtask

  initial begin
    int lat, acks;
    rst_i = 1'b1; init_req_i = 1'b0; vid_req_i = 1'b0; vid_addr_i = 8'h0;
    cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 8'h0; cpu_ben_i = 2'b0; cpu_wdata_i = 16'h0;
    last_rd = 16'h0;
    repeat (3) tick();
    check_eq("rst_wr_en", ram_wr_en_o, 0);
    check_eq("rst_ben", ram_ben_o, 0);
    check_eq("rst_wr_addr", ram_wr_addr_o, 0);
    check_eq("rst_wr_data", ram_wr_data_o, 0);
    check_eq("rst_ack", cpu_ack_o, 0);
    check_eq("rst_rdata", cpu_rdata_o, 0);
    check_eq("rst_vid_valid", vid_valid_o, 0);
    check_eq("rst_init_done", init_done_o, 0);

    rst_i = 1'b0;
    load_defaults();
    run_init("init0");
    foreach (DEF[i]) vid_lookup(8'(i));
    vid_lookup(8'd16);
    vid_lookup(8'd255);

    cpu_write(8'h20, 16'h0ABC, 2'b11);
    cpu_read(8'h20);
    vid_lookup(8'h20);
    cpu_write(8'h21, 16'h1234, 2'b00);
    cpu_write(8'h22, 16'h5566, 2'b01);
    cpu_read(8'h22);
    cpu_read(8'h21);

    // CPU read starved by 50 cycles of video lookups.
    last_rd = shadow[3];
    cpu_q.push_back(last_rd);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h03;
    acks = 0;
    for (int i = 0; i < 50; i++) begin
      vid_req_i = 1'b1; vid_addr_i = 8'(i * 5);
      vid_q.push_back(shadow[i * 5]);
      tick();
      if (cpu_ack_o) acks++;
    end
    vid_req_i = 1'b0;
    check_eq("starved_acks", acks, 0);
    wait_ack(lat);
    cpu_req_i = 1'b0;
    check_eq("starved_rd_lat", lat, 2);

    // Video reads entry 5 in the cycle the CPU high-byte write lands.
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 8'h05; cpu_ben_i = 2'b10; cpu_wdata_i = 16'h0F00;
    wr_q.push_back({8'h05, 2'b10, 16'h0F00});
    cpu_q.push_back(last_rd);
    tick();
    check_eq("fwd_wr_ack", cpu_ack_o, 1);
    cpu_req_i = 1'b0;
    shadow[5] = 16'h0FC5;
    vid_req_i = 1'b1; vid_addr_i = 8'h05;
    vid_q.push_back(16'h0FC5);
    tick();
    vid_req_i = 1'b0;
    cpu_read(8'h05);

    // Write then immediately read the same entry: CPU path forwarding.
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 8'h07; cpu_ben_i = 2'b11; cpu_wdata_i = 16'h1111;
    wr_q.push_back({8'h07, 2'b11, 16'h1111});
    cpu_q.push_back(last_rd);
    tick();
    check_eq("fwd2_wr_ack", cpu_ack_o, 1);
    shadow[7] = 16'h1111;
    last_rd = 16'h1111;
    cpu_q.push_back(last_rd);
    cpu_we_i = 1'b0;
    wait_ack(lat);
    cpu_req_i = 1'b0;
    check_eq("fwd2_rd_lat", lat, 2);

    // Re-init requested while a read is in flight: ack first, then sweep.
    last_rd = shadow[1];
    cpu_q.push_back(last_rd);
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h01;
    tick();
    init_req_i = 1'b1;
    tick();
    init_req_i = 1'b0;
    check_eq("reinit_rd_ack", cpu_ack_o, 1);
    check_eq("reinit_done_low", init_done_o, 0);
    load_defaults();
    last_rd = shadow[8'h20];
    cpu_q.push_back(last_rd);
    cpu_addr_i = 8'h20;
    run_init("reinit");
    wait_ack(lat);
    cpu_req_i = 1'b0;
    check_eq("post_init_rd_lat", lat, 2);

    // Reset one cycle after a read issues: no ack, sweep restarts at 0.
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 8'h02;
    tick();
    rst_i = 1'b1; vid_req_i = 1'b1; vid_addr_i = 8'h02;
    tick();
    cpu_req_i = 1'b0; vid_req_i = 1'b0;
    check_eq("mid_rst_ack", cpu_ack_o, 0);
    check_eq("mid_rst_vid_valid", vid_valid_o, 0);
    check_eq("mid_rst_done", init_done_o, 0);
    check_eq("mid_rst_rdata", cpu_rdata_o, 0);
    tick();
    check_eq("mid_rst_no_late_ack", cpu_ack_o, 0);
    rst_i = 1'b0;
    last_rd = 16'h0;
    load_defaults();
    run_init("rst_init");
    cpu_read(8'h01);
    cpu_read(8'h0F);
    cpu_read(8'h10);
    vid_lookup(8'h0E);

    repeat (3) tick();
    check_eq("wr_q_left", wr_q.size(), 0);
    check_eq("vid_q_left", vid_q.size(), 0);
    check_eq("cpu_q_left", cpu_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
